// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: PC-control FSM states,
// the existing NPC select codes, and the per-cycle pipeline control bundle.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_RUN    = 2'd0,
    PC_HOLD   = 2'd1,
    PC_REPLAY = 2'd2
  } pc_state_e;

  localparam logic [1:0] NPC_PLUS4  = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_JALR   = 2'd3;

  typedef struct packed {
    logic pc_en;
    logic pc_sel;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_FREEZE   = 8'b0000_0000;
  localparam pipe_ctl_t CTL_NORMAL   = 8'b1010_1011;
  localparam pipe_ctl_t CTL_STALL    = 8'b0000_1111;
  localparam pipe_ctl_t CTL_REDIRECT = 8'b1111_1111;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller for the 5-stage core: turns stall/redirect/memory-hold into
// PC and pipeline-register enables/flushes, replays redirects lost to a hold.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int CNT_W     = 32,
  parameter int MAX_STALL = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall_req,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            ext_hold,
  output logic            pc_en,
  output logic            pc_sel,
  output logic [XLEN-1:0] npc_out,
  output logic            if_id_en,
  output logic            if_id_flush,
  output logic            id_ex_en,
  output logic            id_ex_flush,
  output logic            ex_mem_en,
  output logic            mem_wb_en,
  output logic            stall_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] hold_cnt,
  output logic [1:0]      state_dbg
);

  localparam int RUN_W = $clog2(MAX_STALL + 2);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL + 1);

  pc_state_e        state_q, state_d;
  logic             pend_vld_q, pend_vld_d;
  logic [XLEN-1:0]  pend_pc_q, pend_pc_d;
  logic [RUN_W-1:0] stall_run_q, stall_run_d;
  logic             stall_timeout_q, stall_timeout_d;

  pipe_ctl_t        ctl;
  logic [XLEN-1:0]  npc;
  logic             do_stall;
  logic             do_redirect;

  // State register: state_q records the mode the previous cycle ran in.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= PC_RUN;
      pend_vld_q      <= 1'b0;
      pend_pc_q       <= '0;
      stall_run_q     <= '0;
      stall_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pend_vld_q      <= pend_vld_d;
      pend_pc_q       <= pend_pc_d;
      stall_run_q     <= stall_run_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  // state_d is the mode of the current cycle; the first un-held cycle after a
  // hold with a latched redirect is the replay cycle.
  always_comb begin
    state_d = PC_RUN;
    if (ext_hold) begin
      state_d = PC_HOLD;
    end else if ((state_q == PC_HOLD) && pend_vld_q) begin
      state_d = PC_REPLAY;
    end
  end

  always_comb begin
    ctl         = CTL_FREEZE;
    npc         = '0;
    do_stall    = 1'b0;
    do_redirect = 1'b0;
    if (rstn) begin
      case (state_d)
        PC_HOLD: begin
          ctl = CTL_FREEZE;
        end
        PC_REPLAY: begin
          ctl         = CTL_REDIRECT;
          npc         = pend_pc_q;
          do_redirect = 1'b1;
        end
        default: begin
          // A redirect squashes the instruction that asked to stall.
          if (redirect) begin
            ctl         = CTL_REDIRECT;
            npc         = redirect_pc;
            do_redirect = 1'b1;
          end else if (stall_req) begin
            ctl      = CTL_STALL;
            do_stall = 1'b1;
          end else begin
            ctl = CTL_NORMAL;
          end
        end
      endcase
    end
  end

  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_pc_d  = pend_pc_q;
    if (ext_hold && redirect) begin
      pend_vld_d = 1'b1;
      pend_pc_d  = redirect_pc;
    end else if (state_d == PC_REPLAY) begin
      pend_vld_d = 1'b0;
    end
  end

  // Watchdog: hold cycles neither advance nor break a stall run.
  always_comb begin
    stall_run_d = stall_run_q;
    if (do_stall) begin
      if (stall_run_q != RUN_MAX) begin
        stall_run_d = stall_run_q + RUN_W'(1);
      end
    end else if (state_d != PC_HOLD) begin
      stall_run_d = '0;
    end
    stall_timeout_d = stall_timeout_q | (stall_run_d == RUN_MAX);
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (do_stall),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (do_redirect),
    .count (flush_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (ext_hold),
    .count (hold_cnt)
  );

  assign pc_en         = ctl.pc_en;
  assign pc_sel        = ctl.pc_sel;
  assign if_id_en      = ctl.if_id_en;
  assign if_id_flush   = ctl.if_id_flush;
  assign id_ex_en      = ctl.id_ex_en;
  assign id_ex_flush   = ctl.id_ex_flush;
  assign ex_mem_en     = ctl.ex_mem_en;
  assign mem_wb_en     = ctl.mem_wb_en;
  assign npc_out       = npc;
  assign stall_timeout = stall_timeout_q;
  assign state_dbg     = state_d;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a vector table for the per-cycle control decode plus
// hand-written sequences for the watchdog and reset-during-hold corner cases.
module tb_pipe_ctrl;

  localparam logic [7:0] E_NORM   = 8'b1010_1011;
  localparam logic [7:0] E_STALL  = 8'b0000_1111;
  localparam logic [7:0] E_REDIR  = 8'b1111_1111;
  localparam logic [7:0] E_FREEZE = 8'b0000_0000;
  localparam logic [1:0] S_RUN = 2'd0, S_HOLD = 2'd1, S_REPLAY = 2'd2;
  localparam int NVEC = 17;

  logic        clk;
  logic        rstn;
  logic        stall_req;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ext_hold;
  logic        pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic        ex_mem_en, mem_wb_en, stall_timeout;
  logic [31:0] npc_out, stall_cnt, flush_cnt, hold_cnt;
  logic [1:0]  state_dbg;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        s;
    logic        r;
    logic [31:0] pc;
    logic        h;
    logic [7:0]  e_ctl;
    logic [31:0] e_npc;
    logic [1:0]  e_st;
    int          e_stall;
    int          e_flush;
    int          e_hold;
  } vec_t;

  vec_t vecs[NVEC];

  pipe_ctrl #(.XLEN(32), .CNT_W(32), .MAX_STALL(8)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .stall_req     (stall_req),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .ext_hold      (ext_hold),
    .pc_en         (pc_en),
    .pc_sel        (pc_sel),
    .npc_out       (npc_out),
    .if_id_en      (if_id_en),
    .if_id_flush   (if_id_flush),
    .id_ex_en      (id_ex_en),
    .id_ex_flush   (id_ex_flush),
    .ex_mem_en     (ex_mem_en),
    .mem_wb_en     (mem_wb_en),
    .stall_timeout (stall_timeout),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt),
    .hold_cnt      (hold_cnt),
    .state_dbg     (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic s, logic r, logic [31:0] pc, logic h, logic [7:0] e_ctl,
                              logic [31:0] e_npc, logic [1:0] e_st, int e_stall, int e_flush,
                              int e_hold);
    vec_t v;
    v.s = s; v.r = r; v.pc = pc; v.h = h;
    v.e_ctl = e_ctl; v.e_npc = e_npc; v.e_st = e_st;
    v.e_stall = e_stall; v.e_flush = e_flush; v.e_hold = e_hold;
    return v;
  endfunction

  function automatic logic [7:0] ctl_now();
    return {pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver: apply inputs just after a rising edge, return at the falling edge for sampling.
  task automatic drive(input logic s, input logic r, input logic [31:0] pc, input logic h);
    @(posedge clk);
    #1;
    stall_req   = s;
    redirect    = r;
    redirect_pc = pc;
    ext_hold    = h;
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; stall_req = 1'b0; redirect = 1'b0; redirect_pc = '0; ext_hold = 1'b0;

    vecs[0]  = mk(0, 0, 32'h0,   0, E_NORM,   32'h0,   S_RUN,    0, 0, 0);
    vecs[1]  = mk(1, 0, 32'h0,   0, E_STALL,  32'h0,   S_RUN,    0, 0, 0);
    vecs[2]  = mk(1, 0, 32'h0,   0, E_STALL,  32'h0,   S_RUN,    1, 0, 0);
    vecs[3]  = mk(0, 0, 32'h0,   0, E_NORM,   32'h0,   S_RUN,    2, 0, 0);
    vecs[4]  = mk(1, 1, 32'h40,  0, E_REDIR,  32'h40,  S_RUN,    2, 0, 0);
    vecs[5]  = mk(0, 0, 32'h0,   0, E_NORM,   32'h0,   S_RUN,    2, 1, 0);
    vecs[6]  = mk(0, 0, 32'h0,   1, E_FREEZE, 32'h0,   S_HOLD,   2, 1, 0);
    vecs[7]  = mk(0, 1, 32'h80,  1, E_FREEZE, 32'h0,   S_HOLD,   2, 1, 1);
    vecs[8]  = mk(0, 0, 32'h0,   1, E_FREEZE, 32'h0,   S_HOLD,   2, 1, 2);
    vecs[9]  = mk(1, 1, 32'h99,  0, E_REDIR,  32'h80,  S_REPLAY, 2, 1, 3);
    vecs[10] = mk(0, 0, 32'h0,   0, E_NORM,   32'h0,   S_RUN,    2, 2, 3);
    vecs[11] = mk(0, 1, 32'h100, 1, E_FREEZE, 32'h0,   S_HOLD,   2, 2, 3);
    vecs[12] = mk(0, 1, 32'h104, 1, E_FREEZE, 32'h0,   S_HOLD,   2, 2, 4);
    vecs[13] = mk(0, 0, 32'h0,   0, E_REDIR,  32'h104, S_REPLAY, 2, 2, 5);
    vecs[14] = mk(0, 0, 32'h0,   1, E_FREEZE, 32'h0,   S_HOLD,   2, 3, 5);
    vecs[15] = mk(1, 0, 32'h0,   0, E_STALL,  32'h0,   S_RUN,    2, 3, 6);
    vecs[16] = mk(0, 0, 32'h0,   0, E_NORM,   32'h0,   S_RUN,    3, 3, 6);

    // Reset values while rstn is low
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset ctl", {24'h0, ctl_now()}, 32'h0);
    check("reset npc", npc_out, 32'h0);
    check("reset timeout", {31'h0, stall_timeout}, 32'h0);
    check("reset cnts", stall_cnt | flush_cnt | hold_cnt, 32'h0);
    rstn = 1'b1;

    // Table-driven decode, counters and state
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].s, vecs[i].r, vecs[i].pc, vecs[i].h);
      check($sformatf("v%0d ctl", i), {24'h0, ctl_now()}, {24'h0, vecs[i].e_ctl});
      check($sformatf("v%0d npc", i), npc_out, vecs[i].e_npc);
      check($sformatf("v%0d state", i), {30'h0, state_dbg}, {30'h0, vecs[i].e_st});
      check($sformatf("v%0d stall_cnt", i), stall_cnt, 32'(vecs[i].e_stall));
      check($sformatf("v%0d flush_cnt", i), flush_cnt, 32'(vecs[i].e_flush));
      check($sformatf("v%0d hold_cnt", i), hold_cnt, 32'(vecs[i].e_hold));
      check($sformatf("v%0d timeout", i), {31'h0, stall_timeout}, 32'h0);
    end

    // Watchdog: 9 stall cycles split by a hold cycle, which must not break the run
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 32'h0, 0);
      check($sformatf("wd stall%0d timeout", i), {31'h0, stall_timeout}, 32'h0);
    end
    drive(0, 0, 32'h0, 1);
    check("wd hold timeout", {31'h0, stall_timeout}, 32'h0);
    for (int i = 4; i < 9; i++) begin
      drive(1, 0, 32'h0, 0);
      check($sformatf("wd stall%0d timeout", i), {31'h0, stall_timeout}, 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 32'h0, 0);
      check($sformatf("wd after%0d timeout", i), {31'h0, stall_timeout}, 32'h1);
      check($sformatf("wd after%0d ctl", i), {24'h0, ctl_now()}, {24'h0, E_NORM});
    end
    check("wd stall_cnt", stall_cnt, 32'd12);
    check("wd hold_cnt", hold_cnt, 32'd7);

    // Reset mid-hold with a redirect pending: nothing survives, no replay afterwards
    drive(0, 1, 32'h200, 1);
    drive(0, 0, 32'h0, 1);
    #2;
    rstn = 1'b0;
    #1;
    check("rst mid ctl", {24'h0, ctl_now()}, 32'h0);
    check("rst mid npc", npc_out, 32'h0);
    check("rst mid timeout", {31'h0, stall_timeout}, 32'h0);
    check("rst mid cnts", stall_cnt | flush_cnt | hold_cnt, 32'h0);
    @(posedge clk);
    #1;
    ext_hold = 1'b0;
    rstn     = 1'b1;
    @(negedge clk);
    check("post rst ctl", {24'h0, ctl_now()}, {24'h0, E_NORM});
    check("post rst state", {30'h0, state_dbg}, {30'h0, S_RUN});
    drive(0, 0, 32'h0, 0);
    check("post rst2 ctl", {24'h0, ctl_now()}, {24'h0, E_NORM});
    check("post rst2 npc", npc_out, 32'h0);
    check("post rst flush_cnt", flush_cnt, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
